// File: rtl/bruh_nios2_gen2_0_cpu_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bruh_nios2_gen2_0_cpu_debug_pkg
// Brief    : Shared types and JTAG data field positions for the debug memory.
// Revision : 1.0
// ============================================================================
package bruh_nios2_gen2_0_cpu_debug_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_DATA = 2'd2,
        WR_REQ  = 2'd3
    } mem_state_e;

    localparam int JDO_W         = 38;
    localparam int JDO_RDFLAG    = 34;
    localparam int JDO_ADDR_LSB  = 26;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int WORD_W        = 32;
    localparam int BE_W          = 4;

endpackage
`default_nettype wire

// File: rtl/bruh_nios2_gen2_0_cpu_debug_mem_ram.sv
`default_nettype none
// ============================================================================
// Module   : bruh_nios2_gen2_0_cpu_debug_mem_ram
// Brief    : Single-port 2^AW x 32 RAM, byte enables, registered read data.
// Revision : 1.0
// ============================================================================
module bruh_nios2_gen2_0_cpu_debug_mem_ram
    import bruh_nios2_gen2_0_cpu_debug_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     addr,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] mem [0:(1<<AW)-1];
    logic [WORD_W-1:0] q_d;
    logic [WORD_W-1:0] q_q;

    // Storage is never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        q_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/bruh_nios2_gen2_0_cpu_debug_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bruh_nios2_gen2_0_cpu_debug_mem_ctrl
// Brief    : JTAG debug word access to monitor RAM, shared with the CPU port.
// Revision : 1.0
// ============================================================================
module bruh_nios2_gen2_0_cpu_debug_mem_ctrl
    import bruh_nios2_gen2_0_cpu_debug_pkg::*;
#(
    parameter int          AW            = 8,
    parameter int unsigned PROTECT_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [AW-1:0]     cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [WORD_W-1:0] cpu_writedata,
    input  logic [BE_W-1:0]   cpu_byteenable,
    output logic [WORD_W-1:0] cpu_readdata,
    output logic [WORD_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    mem_state_e        state_q, state_d;
    logic [AW-1:0]     mon_areg_q, mon_areg_d;
    logic [WORD_W-1:0] mon_dreg_q, mon_dreg_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;

    logic              w_cpu_busy;
    logic              w_any_strobe;
    logic              w_protected;
    logic              w_jtag_wr;
    logic [AW-1:0]     w_areg_inc;
    logic [AW-1:0]     w_ram_addr;
    logic              w_ram_we;
    logic [BE_W-1:0]   w_ram_be;
    logic [WORD_W-1:0] w_ram_wdata;
    logic [WORD_W-1:0] w_ram_q;
    logic              unused_jdo;

    assign unused_jdo   = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};
    assign w_cpu_busy   = cpu_read | cpu_write;
    assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_protected  = (32'(mon_areg_q) < PROTECT_WORDS);
    assign w_areg_inc   = mon_areg_q + {{(AW-1){1'b0}}, 1'b1};

    // The CPU owns the RAM port whenever it strobes; JTAG only fills idle cycles.
    assign w_jtag_wr   = (state_q == WR_REQ) & ~w_cpu_busy;
    assign w_ram_addr  = w_cpu_busy ? cpu_address : mon_areg_q;
    assign w_ram_we    = ~reset & (cpu_write | w_jtag_wr);
    assign w_ram_be    = cpu_write ? cpu_byteenable : {BE_W{1'b1}};
    assign w_ram_wdata = cpu_write ? cpu_writedata : mon_dreg_q;

    bruh_nios2_gen2_0_cpu_debug_mem_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .addr  (w_ram_addr),
        .we    (w_ram_we),
        .be    (w_ram_be),
        .wdata (w_ram_wdata),
        .q     (w_ram_q)
    );

    always_comb begin
        state_d    = state_q;
        mon_areg_d = mon_areg_q;
        mon_dreg_d = mon_dreg_q;
        ready_d    = ready_q;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    mon_areg_d = jdo[JDO_ADDR_LSB +: AW];
                    ready_d    = 1'b0;
                    error_d    = 1'b0;
                    if (jdo[JDO_RDFLAG]) begin
                        state_d = RD_REQ;
                    end
                end else if (take_action_ocimem_b) begin
                    mon_dreg_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                    if (w_protected) begin
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        ready_d = 1'b0;
                        state_d = WR_REQ;
                    end
                end else if (take_no_action_ocimem_a) begin
                    ready_d = 1'b0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (w_any_strobe) begin
                    error_d = 1'b1;
                end
                if (!w_cpu_busy) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (w_any_strobe) begin
                    error_d = 1'b1;
                end
                mon_dreg_d = w_ram_q;
                mon_areg_d = w_areg_inc;
                ready_d    = 1'b1;
                state_d    = IDLE;
            end
            WR_REQ: begin
                if (w_any_strobe) begin
                    error_d = 1'b1;
                end
                if (!w_cpu_busy) begin
                    mon_areg_d = w_areg_inc;
                    ready_d    = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mon_areg_q <= '0;
            mon_dreg_q <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mon_areg_q <= mon_areg_d;
            mon_dreg_q <= mon_dreg_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    assign cpu_readdata  = w_ram_q;
    assign MonDReg       = mon_dreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_bruh_nios2_gen2_0_cpu_debug_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bruh_nios2_gen2_0_cpu_debug_mem_ctrl
// Brief    : Self-checking bench with a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_bruh_nios2_gen2_0_cpu_debug_mem_ctrl;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mem_m [256];
    logic [7:0]  areg_m;
    logic [31:0] dreg_m;
    logic        ready_m;
    logic        error_m;

    bruh_nios2_gen2_0_cpu_debug_mem_ctrl #(
        .AW            (AW),
        .PROTECT_WORDS (64)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ready"}, 32'(monitor_ready), 32'(ready_m));
        check({tag, "_error"}, 32'(monitor_error), 32'(error_m));
        check({tag, "_dreg"}, MonDReg, dreg_m);
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd);
        logic [37:0] j;
        j        = 38'($urandom) & ~38'h3F_FC00_0000;
        j[33:26] = addr;
        j[34]    = rd;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] j;
        j       = '0;
        j[34:3] = data;
        return j;
    endfunction

    task automatic cpu_write_word(input logic [7:0] addr, input logic [31:0] data,
                                  input logic [3:0] be);
        cpu_write      = 1'b1;
        cpu_address    = addr;
        cpu_writedata  = data;
        cpu_byteenable = be;
        tick();
        cpu_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_m[addr][8*i +: 8] = data[8*i +: 8];
        end
    endtask

    task automatic cpu_read_word(input logic [7:0] addr);
        cpu_read    = 1'b1;
        cpu_address = addr;
        tick();
        cpu_read = 1'b0;
        check("cpu_rd", cpu_readdata, mem_m[addr]);
    endtask

    // CPU reads issued while a JTAG request waits; each one delays JTAG by a cycle.
    task automatic stall_cycles(input int stall);
        logic [7:0] a;
        for (int s = 0; s < stall; s++) begin
            a           = 8'($urandom);
            cpu_read    = 1'b1;
            cpu_address = a;
            tick();
            check("stall_cpu_rd", cpu_readdata, mem_m[a]);
        end
        cpu_read = 1'b0;
    endtask

    task automatic jtag_set_addr(input logic [7:0] addr);
        jdo                  = mk_a(addr, 1'b0);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        areg_m  = addr;
        ready_m = 1'b0;
        error_m = 1'b0;
        check_flags("set_addr");
    endtask

    task automatic jtag_read(input logic use_a, input logic [7:0] addr, input int stall,
                             input logic busy_strobe);
        if (use_a) begin
            jdo                  = mk_a(addr, 1'b1);
            take_action_ocimem_a = 1'b1;
            areg_m               = addr;
            error_m              = 1'b0;
        end else begin
            take_no_action_ocimem_a = 1'b1;
        end
        ready_m = 1'b0;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        check_flags("rd_req");
        stall_cycles(stall);
        tick();
        check("rd_pending_ready", 32'(monitor_ready), 32'(0));
        if (busy_strobe) begin
            jdo                  = mk_b(~mem_m[areg_m]);
            take_action_ocimem_b = 1'b1;
            error_m              = 1'b1;
        end
        tick();
        take_action_ocimem_b = 1'b0;
        dreg_m  = mem_m[areg_m];
        areg_m  = areg_m + 8'd1;
        ready_m = 1'b1;
        check_flags("rd_done");
    endtask

    task automatic jtag_write(input logic [31:0] data, input int stall);
        jdo                  = mk_b(data);
        take_action_ocimem_b = 1'b1;
        dreg_m               = data;
        if (areg_m < 8'd64) begin
            tick();
            take_action_ocimem_b = 1'b0;
            ready_m = 1'b1;
            error_m = 1'b1;
            check_flags("wr_prot");
        end else begin
            tick();
            take_action_ocimem_b = 1'b0;
            ready_m = 1'b0;
            check_flags("wr_req");
            stall_cycles(stall);
            tick();
            mem_m[areg_m] = data;
            areg_m        = areg_m + 8'd1;
            ready_m       = 1'b1;
            check_flags("wr_done");
        end
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        reset                   = 1'b1;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        cpu_address             = '0;
        cpu_read                = 1'b0;
        cpu_write               = 1'b0;
        cpu_writedata           = '0;
        cpu_byteenable          = '0;
        areg_m  = '0;
        dreg_m  = '0;
        ready_m = 1'b0;
        error_m = 1'b0;

        tick();
        tick();
        check_flags("reset");
        check("reset_cpu_rdata", cpu_readdata, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 256; i++) begin
            cpu_write_word(8'(i), $urandom, 4'hF);
        end

        // Directed read
        cpu_write_word(8'h50, 32'hDEADBEEF, 4'hF);
        jtag_read(1'b1, 8'h50, 0, 1'b0);
        jtag_read(1'b0, 8'h00, 0, 1'b0);

        // Write then read back
        jtag_set_addr(8'h80);
        jtag_write(32'h12345678, 0);
        jtag_read(1'b1, 8'h80, 0, 1'b0);

        // Protected write, RAM untouched, next ocimem_a clears flags
        jtag_set_addr(8'h10);
        jtag_write(~mem_m[8'h10], 0);
        cpu_read_word(8'h10);
        jtag_set_addr(8'h20);

        // CPU contention for three cycles
        jtag_read(1'b1, 8'h60, 3, 1'b0);
        jtag_set_addr(8'hC0);
        jtag_write(32'hA5A5_5A5A, 2);
        cpu_read_word(8'hC0);

        // Address wrap and a strobe while busy
        jtag_read(1'b1, 8'hFF, 0, 1'b0);
        jtag_read(1'b0, 8'h00, 0, 1'b0);
        jtag_read(1'b1, 8'h70, 0, 1'b1);
        jtag_read(1'b1, 8'h71, 0, 1'b0);

        // Simultaneous strobes: ocimem_a wins and nothing is written
        jdo                  = mk_a(8'h90, 1'b0);
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        areg_m  = 8'h90;
        ready_m = 1'b0;
        error_m = 1'b0;
        check_flags("simul");
        jtag_read(1'b0, 8'h00, 0, 1'b0);

        // Reset while in WR_REQ with the CPU stalling
        jtag_set_addr(8'hA0);
        jdo                  = mk_b(~mem_m[8'hA0]);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        cpu_read    = 1'b1;
        cpu_address = 8'hA0;
        reset       = 1'b1;
        tick();
        reset    = 1'b0;
        cpu_read = 1'b0;
        areg_m  = '0;
        dreg_m  = '0;
        ready_m = 1'b0;
        error_m = 1'b0;
        check_flags("rst_mid");
        check("rst_mid_cpu_rdata", cpu_readdata, 32'h0);
        cpu_read_word(8'hA0);
        jtag_read(1'b0, 8'h00, 0, 1'b0);

        // Randomized mix of CPU and JTAG transactions
        for (int n = 0; n < 120; n++) begin
            a = 8'($urandom);
            d = $urandom;
            case ($urandom_range(0, 5))
                0: begin
                    cpu_write_word(a, d, 4'($urandom));
                    check_flags("rnd_cpu_wr");
                end
                1: cpu_read_word(a);
                2: jtag_set_addr(a);
                3: jtag_read(1'b1, a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                4: jtag_read(1'b0, 8'h00, $urandom_range(0, 2), 1'b0);
                default: jtag_write(d, $urandom_range(0, 3));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bruh_nios2_gen2_0_cpu_debug_mem_ctrl.md
# bruh_nios2_gen2_0_cpu_debug_mem_ctrl

Sysclk-domain debug memory controller that consumes the decoded JTAG commands from the CPU debug slave wrapper (`jdo`, `take_action_ocimem_*`) and performs word reads/writes into the on-chip debug monitor RAM. The CPU reaches the same RAM through a fixed-latency slave port. The block returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave, closing the JTAG memory-access loop.

## Interface
- `AW`, default 8: RAM word-address width; depth 2^AW words of 32 bits.
- `PROTECT_WORDS`, default 64: words `0..PROTECT_WORDS-1` are read-only from JTAG. A value of 0 disables protection.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  JTAG data, qualified only by the strobes below.
- `take_action_ocimem_a`  in  1  1-cycle strobe: load address, optionally start a read.
- `take_no_action_ocimem_a`  in  1  1-cycle strobe: read at the current address.
- `take_action_ocimem_b`  in  1  1-cycle strobe: write `jdo[34:3]` at the current address.
- `cpu_address`  in  AW  CPU word address.
- `cpu_read`, `cpu_write`  in  1  CPU access strobes; they are never asserted together.
- `cpu_writedata`  in  32  CPU write data.
- `cpu_byteenable`  in  4  CPU byte lanes.
- `cpu_readdata`  out  32  CPU read data, valid 1 cycle after `cpu_read`.
- `MonDReg`  out  32  JTAG data register.
- `monitor_ready`  out  1  the last JTAG operation completed.
- `monitor_error`  out  1  the last JTAG operation was rejected.

Reset values: `MonDReg`=0, `cpu_readdata`=0, `monitor_ready`=0, `monitor_error`=0, internal `MonAReg`=0, FSM=IDLE.

## Operation
- Internal `MonAReg[AW-1:0]` holds the JTAG word address.
- **`take_action_ocimem_a`:**
  - Loads `MonAReg <= jdo[26+AW-1:26]`.
  - Clears `monitor_ready` and `monitor_error`.
  - If `jdo[34]`=1, the FSM goes to RD_REQ.
- **`take_no_action_ocimem_a`:** clears `monitor_ready`; the FSM goes to RD_REQ.
- **`take_action_ocimem_b`:**
  - Captures `MonDReg <= jdo[34:3]` and clears `monitor_ready`.
  - If `MonAReg < PROTECT_WORDS`, sets `monitor_error` and `monitor_ready`, and the FSM stays IDLE.
  - Otherwise the FSM goes to WR_REQ.
- **FSM states:**
  - IDLE: accepts a strobe.
  - RD_REQ: issues a RAM read when the CPU is not accessing, then goes to RD_DATA.
  - RD_DATA: loads `MonDReg <= ram_q`, `MonAReg <= MonAReg+1`, sets `monitor_ready`, returns to IDLE.
  - WR_REQ: issues a 4-byte RAM write of `MonDReg` when the CPU is not accessing, then `MonAReg+1`, sets `monitor_ready`, returns to IDLE.
- **Arbitration:** the CPU always wins. RD_REQ/WR_REQ hold while `cpu_read|cpu_write`. The CPU never stalls, so there is no waitrequest. JTAG starvation is acceptable because the CPU is halted during debug.
- **Address wrap:** `MonAReg` wraps modulo 2^AW; `2^AW-1 + 1 = 0`.
- **Strobe while busy (FSM not IDLE):** the strobe is dropped, `monitor_error` is set, and the in-flight operation completes normally.
- **Simultaneous strobes in one cycle:** priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`; the others are ignored silently.
- **CPU writes:** honour `cpu_byteenable`. CPU writes are never protected.
- **Reset mid-operation:** the FSM returns to IDLE and the pending JTAG operation is lost. RAM contents are not reset.

## Timing
- Strobe at cycle T:
  - RD_REQ at T+1.
  - RAM read issued at T+1 if the CPU is idle.
  - `MonDReg`/`monitor_ready` valid at T+3.
- Write strobe at T: RAM write at T+1 (CPU idle); `monitor_ready` high at T+2.
- Each cycle of CPU activity during RD_REQ/WR_REQ adds exactly one cycle of latency.
- Protected write: `monitor_error`=`monitor_ready`=1 at T+1.
- CPU read at T: `cpu_readdata` valid at T+1, independent of the FSM.
- `monitor_ready` stays high until the next accepted strobe; the debug slave samples it asynchronously, so it must be glitch-free (registered).

## Structure
- The shared package `bruh_nios2_gen2_0_cpu_debug_pkg` holds:
  - the FSM state enum (IDLE, RD_REQ, RD_DATA, WR_REQ);
  - the `jdo` field constants: `JDO_RDFLAG`=34, `JDO_ADDR_LSB`=26, `JDO_WDATA_MSB`=34, `JDO_WDATA_LSB`=3.
- One sub-module, `bruh_nios2_gen2_0_cpu_debug_mem_ram`:
  - single-port 2^AW×32 RAM;
  - byte enables;
  - registered output (1-cycle read latency);
  - inferable as M9K/M10K.

## Test plan
- **Read:** preload word 0x50 = 0xDEADBEEF; `take_action_ocimem_a` with `jdo[33:26]`=0x50, `jdo[34]`=1 -> `MonDReg`=0xDEADBEEF, `monitor_ready`=1 at T+3, `MonAReg`=0x51.
- **Write then read back:**
  - `ocimem_a` to 0x80 (`jdo[34]`=0), then `ocimem_b` with `jdo[34:3]`=0x12345678 -> `monitor_ready` at T+2;
  - `ocimem_a` to 0x80 with read -> `MonDReg`=0x12345678.
- **Protection:** write at address 0x10 -> `monitor_error`=1, `monitor_ready`=1 at T+1; RAM word 0x10 unchanged; the next `ocimem_a` clears both flags.
- **Contention:** hold `cpu_read` for 3 cycles during RD_REQ -> JTAG result delayed 3 cycles; CPU `readdata` correct every cycle.
- **Wrap and busy:**
  - back-to-back reads from 0xFF -> second read returns word 0x00;
  - a strobe issued during RD_DATA -> `monitor_error`=1, first result intact.
- **Reset in WR_REQ with CPU stalling:** RAM unchanged; all outputs 0; FSM IDLE next cycle.
